// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Purpose:
//   Serializer at the far end of the CPU's UART transmit-data path. Accepts one
//   byte per DataInValid/DataInReady handshake and emits an asynchronous serial
//   frame on SOut at a fixed baud rate: one start bit (0), eight data bits LSB
//   first, optionally an even-parity bit, and one stop bit (1).
//
// Configuration:
//   UART_TX_PARITY_EN  when defined, a parity bit (XOR of the 8 data bits) is
//                      inserted between the data and stop bits (8E1 frame).
//                      When undefined the frame is 8N1 and no parity logic
//                      exists.
//
// Parameters:
//   ClockFreq    system clock frequency in Hz
//   BaudRate     serial bit rate in bits/s
//   ClockFreq/BaudRate (cycles per serial bit) must be at least 2.
//
// Ports:
//   Clock        system clock, rising edge
//   Reset        asynchronous, active-high reset
//   DataIn       byte to transmit, sampled only on the handshake edge
//   DataInValid  producer has a byte on DataIn
//   DataInReady  transmitter idle and able to accept a byte (registered)
//   SOut         serial line, idles high (registered, glitch-free)
// -----------------------------------------------------------------------------
module uart_transmitter #(
   parameter int ClockFreq = 50_000_000,
   parameter int BaudRate  = 115_200
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] DataIn,
   input  logic       DataInValid,
   output logic       DataInReady,
   output logic       SOut
);

   localparam int SymbolEdgeTime    = ClockFreq / BaudRate;
   localparam int ClockCounterWidth = $clog2(SymbolEdgeTime);
   localparam logic [ClockCounterWidth-1:0] TerminalCount =
      ClockCounterWidth'(SymbolEdgeTime - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateT;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} stateT;
`endif

   stateT                        state, stateNext;
   logic [ClockCounterWidth-1:0] clockCounter, clockCounterNext;
   logic [2:0]                   bitIndex, bitIndexNext;
   logic [7:0]                   shiftReg, shiftRegNext;
   logic                         sOutNext;
   logic                         readyNext;
   logic                         terminal;
`ifdef UART_TX_PARITY_EN
   logic                         parityBit, parityBitNext;
`endif

   assign terminal = (clockCounter == TerminalCount);

   // Every state element, including both outputs, lives in this one register
   // process so SOut and DataInReady come straight from flops.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         clockCounter <= '0;
         bitIndex     <= '0;
         shiftReg     <= '0;
         SOut         <= 1'b1;
         DataInReady  <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parityBit    <= 1'b0;
`endif
      end else begin
         state        <= stateNext;
         clockCounter <= clockCounterNext;
         bitIndex     <= bitIndexNext;
         shiftReg     <= shiftRegNext;
         SOut         <= sOutNext;
         DataInReady  <= readyNext;
`ifdef UART_TX_PARITY_EN
         parityBit    <= parityBitNext;
`endif
      end
   end

   // Next-state logic. SOut only changes on a bit-counter terminal count or on
   // the handshake edge; the shift register always presents the next data bit
   // in bit 0, so each data transition loads shiftReg[0] and shifts right.
   always_comb begin
      stateNext        = state;
      clockCounterNext = clockCounter + ClockCounterWidth'(1);
      bitIndexNext     = bitIndex;
      shiftRegNext     = shiftReg;
      sOutNext         = SOut;
      readyNext        = DataInReady;
`ifdef UART_TX_PARITY_EN
      parityBitNext    = parityBit;
`endif

      case (state)
         IDLE: begin
            clockCounterNext = '0;
            sOutNext         = 1'b1;
            readyNext        = 1'b1;
            if (DataInValid && DataInReady) begin
               shiftRegNext = DataIn;
               sOutNext     = 1'b0;
               readyNext    = 1'b0;
               stateNext    = START;
`ifdef UART_TX_PARITY_EN
               parityBitNext = ^DataIn;
`endif
            end
         end

         START: begin
            if (terminal) begin
               clockCounterNext = '0;
               bitIndexNext     = '0;
               sOutNext         = shiftReg[0];
               shiftRegNext     = {1'b0, shiftReg[7:1]};
               stateNext        = DATA;
            end
         end

         DATA: begin
            if (terminal) begin
               clockCounterNext = '0;
               if (bitIndex == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  sOutNext  = parityBit;
                  stateNext = PARITY;
`else
                  sOutNext  = 1'b1;
                  stateNext = STOP;
`endif
               end else begin
                  bitIndexNext = bitIndex + 3'd1;
                  sOutNext     = shiftReg[0];
                  shiftRegNext = {1'b0, shiftReg[7:1]};
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (terminal) begin
               clockCounterNext = '0;
               sOutNext         = 1'b1;
               stateNext        = STOP;
            end
         end
`endif

         STOP: begin
            // Ready rises on the same edge the frame ends, so a held
            // DataInValid starts the next frame one cycle later.
            if (terminal) begin
               clockCounterNext = '0;
               readyNext        = 1'b1;
               stateNext        = IDLE;
            end
         end

         default: begin
            clockCounterNext = '0;
            bitIndexNext     = '0;
            sOutNext         = 1'b1;
            readyNext        = 1'b1;
            stateNext        = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Self-checking bench for uart_transmitter with ClockFreq=1000, BaudRate=100
// (10 clock cycles per serial bit). Expected line levels come from a frame
// model (start, data LSB first, optional parity, stop) and a mid-bit sampling
// receiver applied to captured SOut samples.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

   localparam int ClockFreq = 1000;
   localparam int BaudRate  = 100;
   localparam int Sym       = ClockFreq / BaudRate;
`ifdef UART_TX_PARITY_EN
   localparam int FrameBits = 11;
`else
   localparam int FrameBits = 10;
`endif
   localparam int FrameCycles = FrameBits * Sym;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [7:0] DataIn;
   logic       DataInValid;
   logic       DataInReady;
   logic       SOut;

   int checks = 0;
   int errors = 0;

   logic cap [0:1023];
   int   capLen;

   uart_transmitter #(
      .ClockFreq(ClockFreq),
      .BaudRate (BaudRate)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .DataIn     (DataIn),
      .DataInValid(DataInValid),
      .DataInReady(DataInReady),
      .SOut       (SOut)
   );

   always #5 Clock = ~Clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Line level for serial bit slot idx of a frame carrying byte b.
   function automatic logic modelBit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (FrameBits == 11 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Receiver: find a start bit at or after 'from' in the captured samples,
   // sample each bit in its middle, and verify parity (if any) and stop.
   task automatic rxDecode(input int from, output int startIdx,
                           output logic [7:0] rxByte, output logic frameOk);
      startIdx = -1;
      rxByte   = '0;
      frameOk  = 1'b0;
      for (int i = from; i < capLen; i++) begin
         if (cap[i] === 1'b0) begin
            startIdx = i;
            break;
         end
      end
      if (startIdx >= 0 && startIdx + FrameCycles < capLen) begin
         for (int j = 0; j < 8; j++)
            rxByte[j] = cap[startIdx + Sym*(j+1) + Sym/2];
         frameOk = (cap[startIdx + Sym*(FrameBits-1) + Sym/2] === 1'b1);
         if (FrameBits == 11)
            frameOk = frameOk && (cap[startIdx + Sym*9 + Sym/2] === ^rxByte);
      end
   endtask

   // One frame from idle with a single-cycle DataInValid. DataIn is scrambled
   // while busy, and a stray DataInValid pulse is issued at cycle pulseAt
   // (negative for none); neither may affect the line.
   task automatic sendFrame(input logic [7:0] b, input int pulseAt, input string tag);
      int soutBad;
      int readyBad;
      int idleBad;
      logic readyBack;
      soutBad  = 0;
      readyBad = 0;
      idleBad  = 0;
      readyBack = 1'b0;
      DataIn      = b;
      DataInValid = 1'b1;
      tick();
      for (int k = 0; k <= FrameCycles; k++) begin
         if (k > 0) tick();
         if (k < FrameCycles) begin
            if (SOut !== modelBit(b, k / Sym)) soutBad++;
            if (DataInReady !== 1'b0) readyBad++;
         end else begin
            readyBack = DataInReady;
         end
         DataIn      = 8'($urandom);
         DataInValid = (k == pulseAt);
      end
      check($sformatf("%s_sout_mismatch_cycles", tag), soutBad, 0);
      check($sformatf("%s_ready_not_low_cycles", tag), readyBad, 0);
      check($sformatf("%s_ready_after_frame", tag), readyBack, 1);
      for (int k = 0; k < 15; k++) begin
         tick();
         if (SOut !== 1'b1 || DataInReady !== 1'b1) idleBad++;
      end
      check($sformatf("%s_idle_after_frame", tag), idleBad, 0);
   endtask

   initial begin
      int bad;
      int lowCnt;
      int s1, s2;
      logic [7:0] r1, r2;
      logic ok1, ok2;
      logic [7:0] rb;

      // Reset state, visible before any clock edge.
      Reset       = 1'b1;
      DataIn      = 8'h00;
      DataInValid = 1'b0;
      #3;
      check("reset_sout_no_clock", SOut, 1);
      check("reset_ready_no_clock", DataInReady, 1);
      DataInValid = 1'b1;
      tick();
      tick();
      check("reset_blocks_handshake_sout", SOut, 1);
      check("reset_blocks_handshake_ready", DataInReady, 1);
      DataInValid = 1'b0;
      Reset = 1'b0;

      // Idle for 50 cycles.
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (SOut !== 1'b1 || DataInReady !== 1'b1) bad++;
      end
      check("idle_50_cycles", bad, 0);

      // 0x55 with a single-cycle valid.
      sendFrame(8'h55, -1, "byte55");

      // 0xA3 then 0x0F with valid held high; DataIn scrambled during frame 1.
      capLen = 2*FrameCycles + 21;
      lowCnt = 0;
      DataIn      = 8'hA3;
      DataInValid = 1'b1;
      for (int i = 0; i < capLen; i++) begin
         tick();
         cap[i] = SOut;
         if (DataInReady === 1'b0) lowCnt++;
         if (i < FrameCycles - 1) DataIn = 8'($urandom);
         else if (i == FrameCycles - 1) DataIn = 8'h0F;
         else if (i >= FrameCycles + 1) begin
            DataInValid = 1'b0;
            DataIn      = 8'($urandom);
         end
      end
      rxDecode(0, s1, r1, ok1);
      rxDecode(s1 + FrameCycles, s2, r2, ok2);
      check("b2b_first_start", s1, 0);
      check("b2b_first_byte", r1, 8'hA3);
      check("b2b_first_frame_ok", ok1, 1);
      check("b2b_second_byte", r2, 8'h0F);
      check("b2b_second_frame_ok", ok2, 1);
      check("b2b_idle_gap", s2 - (s1 + FrameCycles), 1);
      check("b2b_ready_low_cycles", lowCnt, 2*FrameCycles);
      for (int k = 0; k < 10; k++) tick();

      // 0xFF aborted by reset at cycle 35 (mid-data).
      DataIn      = 8'hFF;
      DataInValid = 1'b1;
      tick();
      DataInValid = 1'b0;
      for (int k = 1; k <= 35; k++) tick();
      check("abort_ready_low_before", DataInReady, 0);
      Reset = 1'b1;
      #1;
      check("abort_sout_no_clock", SOut, 1);
      check("abort_ready_no_clock", DataInReady, 1);
      tick();
      Reset = 1'b0;
      tick();
      check("abort_ready_after_release", DataInReady, 1);
      check("abort_sout_after_release", SOut, 1);
      sendFrame(8'h00, -1, "byte00_after_abort");

      // Random byte aborted during its start bit: line must jump 0 -> 1.
      rb = 8'($urandom);
      DataIn      = rb;
      DataInValid = 1'b1;
      tick();
      DataInValid = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      check("abort_start_sout_before", SOut, 0);
      Reset = 1'b1;
      #1;
      check("abort_start_sout_no_clock", SOut, 1);
      tick();
      Reset = 1'b0;
      tick();

      // Parity-sensitive bytes.
      sendFrame(8'h07, -1, "byte07");
      sendFrame(8'h03, -1, "byte03");

      // Stray valid pulse mid-frame must not produce a second frame.
      sendFrame(8'h3C, 40, "pulse_ignored");

      // Randomized bytes with random stray pulses.
      for (int r = 0; r < 6; r++)
         sendFrame(8'($urandom_range(0, 255)),
                   int'($urandom_range(1, FrameCycles - 2)),
                   $sformatf("rand%0d", r));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serializer at the far end of the CPU's UART transmit-data path.
- Accepts one byte per DataInValid/DataInReady handshake. The CPU's memory-mapped store to 0x80000008 drives DataIn/DataInValid; a load of 0x80000000 reads DataInReady.
- Emits an asynchronous serial frame on SOut at a fixed baud rate. Default frame is 8N1, LSB first.

Parameters:
- ClockFreq, 50_000_000, system clock frequency in Hz.
- BaudRate, 115_200, serial bit rate in bits/s.
- SymbolEdgeTime (localparam), ClockFreq/BaudRate truncated, clock cycles per serial bit. Must be >= 2.
- ClockCounterWidth (localparam), $clog2(SymbolEdgeTime), width of the bit-period counter.

Ports:
- Clock  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- DataIn  input  8  byte to transmit; sampled only on handshake.
- DataInValid  input  1  producer has a byte on DataIn.
- DataInReady  output  1  transmitter idle and able to accept a byte.
- SOut  output  1  serial line; idles high.

Behaviour:
- Clocking and reset:
  - One clock domain; all state and outputs are registered.
  - Reset is asynchronous and active-high.
  - While Reset is high: SOut=1, DataInReady=1, state=IDLE, counters=0, shift register=0.
  - Reset asserted mid-frame aborts the frame immediately: SOut returns to 1 with no clock required.
  - No handshake is accepted while Reset is high.
- Handshake:
  - Transfer occurs at a rising edge where DataInValid && DataInReady.
  - At that edge: DataIn is latched into the shift register, DataInReady goes 0, SOut goes 0 (start bit), and the state moves to START.
  - DataInValid without DataInReady is ignored; the producer must hold the data.
  - DataIn changes while busy have no effect.
- States:
  - IDLE: SOut=1, DataInReady=1.
  - START: SOut=0 for SymbolEdgeTime cycles, then DATA.
  - DATA: 8 bits, LSB first, each bit held SymbolEdgeTime cycles. A bit index of 0..7 advances on each bit-counter terminal count. After bit 7, go to STOP, or to PARITY when the optional feature is enabled.
  - STOP: SOut=1 for SymbolEdgeTime cycles. On terminal count, return to IDLE and set DataInReady to 1 on the same edge.
- Bit timing:
  - The bit counter resets to 0 on every bit transition and counts to SymbolEdgeTime-1.
  - Terminal count occurs when the counter equals SymbolEdgeTime-1.
  - SOut changes only on terminal-count edges (or on the handshake edge).
- Frame length: DataInReady is low for exactly 10*SymbolEdgeTime cycles (11*SymbolEdgeTime with parity).
- Back-to-back frames: with DataInValid held high, the next handshake occurs one cycle after DataInReady rises. There is therefore exactly one idle-high cycle between the stop bit and the next start bit.
- No glitches: SOut is driven directly from a flop.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - SOut = XOR of the 8 latched data bits (even parity), held SymbolEdgeTime cycles.
  - Frame is 8E1 (11 bits).
- Undefined:
  - No PARITY state; frame is 8N1 (10 bits).
  - No parity logic is synthesized.

Test Plan:
All scenarios use ClockFreq=1000, BaudRate=100 (SymbolEdgeTime=10).

1. Reset, then idle for 50 cycles -> SOut=1 and DataInReady=1 throughout; no transitions.
2. Send 0x55 with a single-cycle DataInValid at edge T:
   - SOut = 0,1,0,1,0,1,0,1,0,1, each level held 10 cycles, starting at edge T.
   - DataInReady is low for exactly 100 cycles and high at edge T+100.
3. Send 0xA3 with DataInValid held high, then 0x0F queued behind it:
   - Receiver model decodes 0xA3 then 0x0F.
   - Exactly 1 idle-high cycle separates the two frames.
   - DataIn changes during frame 1 do not corrupt it.
4. Start sending 0xFF, assert Reset asynchronously at cycle 35 of the frame (mid-DATA):
   - SOut=1 before the next clock edge.
   - DataInReady=1 after Reset is released.
   - The next byte, 0x00, is sent intact as 10 cycles low ×9 bits then a high stop bit.
5. With UART_TX_PARITY_EN, send 0x07 then 0x03:
   - Parity bit is 1 for 0x07 and 0 for 0x03.
   - Each frame is 110 cycles.
   - Without the macro, the same stimulus gives 100-cycle frames with no parity bit.
6. DataInValid pulsed while DataInReady=0 (mid-frame) and deasserted before the frame ends:
   - Pulsed byte is not transmitted.
   - Only the original frame appears on SOut.
